// File: rtl/block_drop_ctrl.sv
// Drop sequencer for the tower Y datapath: hands draw jobs to the drawer, then advances level/Y.
// Optional feature: define DRAW_TIMEOUT_EN to abort a stalled draw after DRAW_TIMEOUT cycles.
module block_drop_ctrl #(
    parameter int Y_INIT       = 104,
    parameter int UNIT_BLOCK   = 16,
    parameter int MAX_LEVELS   = 7,
    parameter int DRAW_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       drop_req,
    output logic       drop_ack,
    output logic       draw_req,
    input  logic       draw_done,
    output logic       y_load,
    output logic       y_dec,
    output logic [6:0] curr_y,
    output logic [2:0] level,
    output logic       tower_full,
    output logic       busy,
    output logic       draw_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READY   = 3'd1;
    localparam logic [2:0] DRAW    = 3'd2;
    localparam logic [2:0] ADVANCE = 3'd3;
    localparam logic [2:0] FULL    = 3'd4;

    // The stack must stay on screen and the level must fit its 3-bit port.
    if (Y_INIT < (MAX_LEVELS - 1) * UNIT_BLOCK || Y_INIT > 127 ||
        MAX_LEVELS < 1 || MAX_LEVELS > 7 || DRAW_TIMEOUT < 1) begin : g_param_check
        $error("block_drop_ctrl: illegal parameter combination");
    end

    logic [2:0] state;
    logic       last_level;
    logic       draw_timeout;

    assign last_level = (level == 3'(MAX_LEVELS - 1));

`ifdef DRAW_TIMEOUT_EN
    localparam int CW = $clog2(DRAW_TIMEOUT + 1);
    logic [CW-1:0] draw_cnt;

    // Counter is cleared while waiting in READY, so every DRAW visit starts from zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            draw_cnt <= '0;
            draw_err <= 1'b0;
        end else begin
            if (state == READY)
                draw_cnt <= '0;
            else if (state == DRAW)
                draw_cnt <= draw_cnt + CW'(1);
            if (state == DRAW && !draw_done && draw_timeout)
                draw_err <= 1'b1;
        end
    end

    assign draw_timeout = (draw_cnt == CW'(DRAW_TIMEOUT - 1));
`else
    assign draw_timeout = 1'b0;
    assign draw_err     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            curr_y <= 7'(Y_INIT);
            level  <= 3'd0;
            y_load <= 1'b0;
        end else begin
            y_load <= 1'b0;
            case (state)
                IDLE, FULL: begin
                    if (start) begin
                        y_load <= 1'b1;
                        curr_y <= 7'(Y_INIT);
                        level  <= 3'd0;
                        state  <= READY;
                    end
                end
                READY: begin
                    if (drop_req)
                        state <= DRAW;
                end
                DRAW: begin
                    // A draw_done coinciding with the timeout completes normally.
                    if (draw_done)
                        state <= ADVANCE;
                    else if (draw_timeout)
                        state <= FULL;
                end
                ADVANCE: begin
                    level <= level + 3'd1;
                    if (last_level) begin
                        state <= FULL;
                    end else begin
                        curr_y <= curr_y - 7'(UNIT_BLOCK);
                        state  <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs; y_dec lines up with the curr_y update on the same edge.
    assign draw_req   = (state == DRAW);
    assign drop_ack   = (state == ADVANCE);
    assign y_dec      = (state == ADVANCE) && !last_level;
    assign tower_full = (state == FULL);
    assign busy       = (state == DRAW) || (state == ADVANCE);

endmodule

// File: tb/tb_block_drop_ctrl.sv
// Directed self-checking bench for block_drop_ctrl; inputs driven and outputs sampled on negedge.
// The timeout scenario is exercised only when DRAW_TIMEOUT_EN is defined.
module tb_block_drop_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       drop_req;
    logic       draw_done;
    logic       drop_ack;
    logic       draw_req;
    logic       y_load;
    logic       y_dec;
    logic [6:0] curr_y;
    logic [2:0] level;
    logic       tower_full;
    logic       busy;
    logic       draw_err;

    int checks = 0;
    int errors = 0;

    block_drop_ctrl #(
        .Y_INIT      (104),
        .UNIT_BLOCK  (16),
        .MAX_LEVELS  (7),
        .DRAW_TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .drop_req  (drop_req),
        .drop_ack  (drop_ack),
        .draw_req  (draw_req),
        .draw_done (draw_done),
        .y_load    (y_load),
        .y_dec     (y_dec),
        .curr_y    (curr_y),
        .level     (level),
        .tower_full(tower_full),
        .busy      (busy),
        .draw_err  (draw_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int exp_y;

        resetn    = 1'b0;
        start     = 1'b0;
        drop_req  = 1'b0;
        draw_done = 1'b0;

        // Reset held for two edges
        step();
        step();
        check("rst_curr_y", curr_y, 104);
        check("rst_level", level, 0);
        check("rst_draw_req", draw_req, 0);
        check("rst_drop_ack", drop_ack, 0);
        check("rst_y_load", y_load, 0);
        check("rst_y_dec", y_dec, 0);
        check("rst_full", tower_full, 0);
        check("rst_busy", busy, 0);
        check("rst_draw_err", draw_err, 0);
        resetn = 1'b1;
        step();
        check("idle_no_load", y_load, 0);

        // Single drop with draw_done 5 cycles after drop_req
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_y_load", y_load, 1);
        check("start_curr_y", curr_y, 104);
        check("start_level", level, 0);
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        check("drop_draw_req", draw_req, 1);
        check("drop_busy", busy, 1);
        check("drop_y_load_off", y_load, 0);
        step();
        step();
        step();
        check("draw_req_held", draw_req, 1);
        check("no_early_ack", drop_ack, 0);
        step();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        check("adv_drop_ack", drop_ack, 1);
        check("adv_y_dec", y_dec, 1);
        check("adv_draw_req_off", draw_req, 0);
        check("adv_busy", busy, 1);
        step();
        check("single_curr_y", curr_y, 88);
        check("single_level", level, 1);
        check("single_ack_off", drop_ack, 0);
        check("single_y_dec_off", y_dec, 0);
        check("single_busy_off", busy, 0);

        // Fill the tower: six more drops
        exp_y = 88;
        for (int i = 1; i < 7; i++) begin
            drop_req = 1'b1;
            step();
            drop_req = 1'b0;
            draw_done = 1'b1;
            step();
            draw_done = 1'b0;
            check($sformatf("fill%0d_ack", i), drop_ack, 1);
            check($sformatf("fill%0d_y_dec", i), y_dec, (i < 6) ? 1 : 0);
            step();
            if (i < 6) exp_y = exp_y - 16;
            check($sformatf("fill%0d_curr_y", i), curr_y, exp_y);
            check($sformatf("fill%0d_level", i), level, i + 1);
        end
        check("full_flag", tower_full, 1);
        check("full_curr_y", curr_y, 8);
        check("full_level", level, 7);

        // drop_req in FULL is ignored
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        check("full_drop_no_draw", draw_req, 0);
        step();
        check("full_drop_no_ack", drop_ack, 0);
        check("full_still_full", tower_full, 1);
        check("full_level_hold", level, 7);

        // Restart from FULL
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_y_load", y_load, 1);
        check("restart_curr_y", curr_y, 104);
        check("restart_level", level, 0);
        check("restart_full_off", tower_full, 0);

        // drop_req and start pulsed during DRAW are ignored
        drop_req = 1'b1;
        step();
        drop_req = 1'b1;
        start    = 1'b1;
        step();
        drop_req = 1'b0;
        start    = 1'b0;
        check("ign_draw_req", draw_req, 1);
        check("ign_no_y_load", y_load, 0);
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        check("ign_ack", drop_ack, 1);
        step();
        check("ign_level", level, 1);
        check("ign_curr_y", curr_y, 88);
        check("ign_no_2nd_draw", draw_req, 0);
        step();
        check("ign_no_2nd_draw_b", draw_req, 0);
        check("ign_no_2nd_ack", drop_ack, 0);

        // Reset mid-DRAW
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        check("middraw_req", draw_req, 1);
        resetn = 1'b0;
        step();
        check("middraw_rst_req", draw_req, 0);
        check("middraw_rst_busy", busy, 0);
        check("middraw_rst_y", curr_y, 104);
        check("middraw_rst_level", level, 0);
        resetn = 1'b1;
        step();

        // draw_done and drop_req in IDLE are ignored
        draw_done = 1'b1;
        drop_req  = 1'b1;
        step();
        draw_done = 1'b0;
        drop_req  = 1'b0;
        check("idle_done_no_ack", drop_ack, 0);
        check("idle_drop_no_draw", draw_req, 0);
        step();
        check("idle_still_idle", busy, 0);

`ifdef DRAW_TIMEOUT_EN
        // Draw timeout with DRAW_TIMEOUT=16: 16 cycles of draw_req, then FULL
        start = 1'b1;
        step();
        start = 1'b0;
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("to_draw_req_held", draw_req, 1);
        check("to_no_err_yet", draw_err, 0);
        step();
        check("to_draw_err", draw_err, 1);
        check("to_full", tower_full, 1);
        check("to_draw_req_off", draw_req, 0);
        check("to_no_ack", drop_ack, 0);
        check("to_no_y_dec", y_dec, 0);
        check("to_curr_y", curr_y, 104);
        start = 1'b1;
        step();
        start = 1'b0;
        check("to_err_sticky", draw_err, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
